// File: rtl/dac7611_serial_rx.sv
// ---------------------------------------------------------------------------
// dac7611_serial_rx
//   Receive side of the DAC7611 3-wire serial interface (CLK, SDI, LD).
//   The pins are oversampled with clk_X4. Each DATA_W-bit word (MSB first) is
//   rebuilt, and malformed frames (wrong bit count or a CLK stall) are flagged.
//
// Optional feature: define DAC_RX_FRAME_CNT_EN to add the frame_cnt and
// err_cnt statistics outputs.
//
// Ports
//   clk_X4      in   sample clock (4x the pin CLK rate)
//   rst         in   synchronous reset, active high
//   CLK_3       in   serial clock pin (asynchronous)
//   SDI_4       in   serial data pin (asynchronous)
//   LD_5        in   frame pin; high while bits shift, falling edge ends frame
//   data_out    out  last good word, held until the next good frame
//   data_valid  out  1-cycle pulse when data_out updates
//   frame_err   out  1-cycle pulse on a bad frame (bit count or timeout)
//   bit_cnt     out  bits captured in the current frame, saturates at DATA_W+1
//   frame_cnt   out  (DAC_RX_FRAME_CNT_EN) good frames, wraps
//   err_cnt     out  (DAC_RX_FRAME_CNT_EN) bad frames, saturates at 8'hFF
//
// Handshake: data_valid and frame_err are single-cycle strobes with no
// back-pressure; data_out is stable from the data_valid cycle until the next
// data_valid. The two strobes are mutually exclusive.
// ---------------------------------------------------------------------------
module dac7611_serial_rx #(
   parameter int DATA_W      = 12,
   parameter int SYNC_STAGES = 2,
   parameter int TIMEOUT     = 64
) (
   input  logic              clk_X4,
   input  logic              rst,
   input  logic              CLK_3,
   input  logic              SDI_4,
   input  logic              LD_5,
   output logic [DATA_W-1:0] data_out,
   output logic              data_valid,
   output logic              frame_err,
   output logic [4:0]        bit_cnt
`ifdef DAC_RX_FRAME_CNT_EN
   ,
   output logic [15:0]       frame_cnt,
   output logic [7:0]        err_cnt
`endif
);

   localparam int TO_W   = $clog2(TIMEOUT + 1);
   localparam int FILL_W = $clog2(SYNC_STAGES + 1);
   localparam logic [4:0] BIT_FULL = 5'(DATA_W);
   localparam logic [4:0] BIT_MAX  = 5'(DATA_W + 1);

   typedef enum logic [1:0] {ARM, IDLE, SHIFT} state_t;
   state_t state, state_nxt;

   logic [SYNC_STAGES-1:0] clk_sync, sdi_sync, ld_sync;
   logic                   clk_p, ld_p;
   logic                   clk_s, sdi_s, ld_s;
   logic                   clk_rise, ld_rise, ld_fall;
   logic [FILL_W-1:0]      fill_cnt;
   logic                   sync_ok;
   logic [DATA_W-1:0]      shreg;
   logic [TO_W-1:0]        to_cnt;

   logic start, end_good, end_bad, to_abort, shift_en;

   assign clk_s    = clk_sync[SYNC_STAGES-1];
   assign sdi_s    = sdi_sync[SYNC_STAGES-1];
   assign ld_s     = ld_sync[SYNC_STAGES-1];
   assign clk_rise = clk_s & ~clk_p;
   assign ld_rise  = ld_s & ~ld_p;
   assign ld_fall  = ~ld_s & ld_p;
   // The cleared synchronizers read LD=0 right after reset even if the pin is
   // high. ARM therefore trusts ld_s only once the pipeline has refilled.
   assign sync_ok  = (fill_cnt == FILL_W'(SYNC_STAGES));

   always_ff @(posedge clk_X4) begin
      if (rst) begin
         clk_sync <= '0;
         sdi_sync <= '0;
         ld_sync  <= '0;
         clk_p    <= 1'b0;
         ld_p     <= 1'b0;
         fill_cnt <= '0;
      end else begin
         clk_sync <= {clk_sync[SYNC_STAGES-2:0], CLK_3};
         sdi_sync <= {sdi_sync[SYNC_STAGES-2:0], SDI_4};
         ld_sync  <= {ld_sync[SYNC_STAGES-2:0], LD_5};
         clk_p    <= clk_s;
         ld_p     <= ld_s;
         if (!sync_ok) fill_cnt <= fill_cnt + 1'b1;
      end
   end

   always_ff @(posedge clk_X4) begin
      if (rst) state <= ARM;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      start     = 1'b0;
      end_good  = 1'b0;
      end_bad   = 1'b0;
      to_abort  = 1'b0;
      shift_en  = 1'b0;
      case (state)
         ARM: begin
            if (sync_ok && !ld_s) state_nxt = IDLE;
         end
         IDLE: begin
            if (ld_rise) begin
               start     = 1'b1;
               state_nxt = SHIFT;
            end
         end
         SHIFT: begin
            // LD fall wins over a coincident CLK rise: that edge is dropped.
            if (ld_fall) begin
               state_nxt = IDLE;
               if (bit_cnt == BIT_FULL) end_good = 1'b1;
               else                     end_bad  = 1'b1;
            end else if (to_cnt == TO_W'(TIMEOUT)) begin
               to_abort  = 1'b1;
               state_nxt = ARM;
            end else if (clk_rise) begin
               shift_en = 1'b1;
            end
         end
         default: state_nxt = ARM;
      endcase
   end

   always_ff @(posedge clk_X4) begin
      if (rst) begin
         data_out   <= '0;
         data_valid <= 1'b0;
         frame_err  <= 1'b0;
         bit_cnt    <= '0;
         shreg      <= '0;
         to_cnt     <= '0;
      end else begin
         data_valid <= end_good;
         frame_err  <= end_bad | to_abort;
         if (end_good) data_out <= shreg;
         if (start) begin
            shreg   <= '0;
            bit_cnt <= '0;
            to_cnt  <= '0;
         end else if (shift_en) begin
            shreg  <= {shreg[DATA_W-2:0], sdi_s};
            to_cnt <= '0;
            if (bit_cnt != BIT_MAX) bit_cnt <= bit_cnt + 1'b1;
         end else if (state == SHIFT && !to_abort) begin
            to_cnt <= to_cnt + 1'b1;
         end
      end
   end

`ifdef DAC_RX_FRAME_CNT_EN
   always_ff @(posedge clk_X4) begin
      if (rst) begin
         frame_cnt <= '0;
         err_cnt   <= '0;
      end else begin
         if (end_good) frame_cnt <= frame_cnt + 1'b1;
         if ((end_bad || to_abort) && err_cnt != 8'hFF) err_cnt <= err_cnt + 1'b1;
      end
   end
`endif

endmodule

// File: tb/tb_dac7611_serial_rx.sv
module tb_dac7611_serial_rx;

   logic        clk_X4 = 1'b0;
   logic        rst    = 1'b1;
   logic        clk_pin = 1'b0;
   logic        sdi_pin = 1'b0;
   logic        ld_pin  = 1'b0;
   logic [11:0] data_out;
   logic        data_valid;
   logic        frame_err;
   logic [4:0]  bit_cnt;
`ifdef DAC_RX_FRAME_CNT_EN
   logic [15:0] frame_cnt;
   logic [7:0]  err_cnt;
`endif

   int n_tests = 0;
   int n_fail  = 0;
   int both_hi = 0;

   dac7611_serial_rx dut (
      .clk_X4     (clk_X4),
      .rst        (rst),
      .CLK_3      (clk_pin),
      .SDI_4      (sdi_pin),
      .LD_5       (ld_pin),
      .data_out   (data_out),
      .data_valid (data_valid),
      .frame_err  (frame_err),
      .bit_cnt    (bit_cnt)
`ifdef DAC_RX_FRAME_CNT_EN
      ,
      .frame_cnt  (frame_cnt),
      .err_cnt    (err_cnt)
`endif
   );

   // clock / reset
   always #5 clk_X4 = ~clk_X4;

   always @(negedge clk_X4) if (data_valid && frame_err) both_hi++;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // driver tasks: pins change on the falling edge, away from sampling
   task automatic tick(input int n);
      repeat (n) @(negedge clk_X4);
   endtask

   task automatic ld_up();
      ld_pin = 1'b1;
      tick(2);
   endtask

   task automatic ld_down();
      ld_pin = 1'b0;
   endtask

   task automatic send_bits(input logic [15:0] val, input int nbits);
      for (int i = nbits - 1; i >= 0; i--) begin
         sdi_pin = val[i];
         clk_pin = 1'b0;
         tick(2);
         clk_pin = 1'b1;
         tick(2);
         clk_pin = 1'b0;
         tick(2);
      end
   endtask

   task automatic send_frame(input logic [15:0] val, input int nbits);
      ld_up();
      send_bits(val, nbits);
      ld_down();
   endtask

   // Waits up to max cycles for a strobe; lat counts cycles from the call.
   task automatic wait_result(input int max, output int lat, output bit v, output bit e);
      lat = 0; v = 1'b0; e = 1'b0;
      while (lat < max && !v && !e) begin
         tick(1);
         lat++;
         if (data_valid) v = 1'b1;
         if (frame_err)  e = 1'b1;
      end
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick(3);
      rst = 1'b0;
      tick(5);
   endtask

   initial begin
      int  lat;
      bit  v, e;
      int  nvalid;

      // reset state
      rst = 1'b1;
      tick(3);
      check("rst_data_out", 32'(data_out), 32'h0);
      check("rst_valid",    32'(data_valid), 32'h0);
      check("rst_err",      32'(frame_err), 32'h0);
      check("rst_bit_cnt",  32'(bit_cnt), 32'h0);
      rst = 1'b0;
      tick(5);

      // periodic transmitter: one 12'h400 frame per 200 cycles, 1000 cycles
      nvalid = 0;
      for (int f = 0; f < 5; f++) begin
         send_frame(16'h0400, 12);
         wait_result(10, lat, v, e);
         if (v) nvalid++;
         check("dac_err", 32'(e), 32'h0);
         check("dac_data", 32'(data_out), 32'h400);
         tick(200 - 74 - lat);
      end
      check("dac_valid_cnt", 32'(nvalid), 32'd5);

      // good frame with latency check
      send_frame(16'h0AC3, 12);
      wait_result(10, lat, v, e);
      check("ac3_valid", 32'(v), 32'h1);
      check("ac3_latency", 32'(lat), 32'd3);
      check("ac3_data", 32'(data_out), 32'hAC3);
      tick(4);

      // short frame
      send_frame(16'h0555, 11);
      wait_result(10, lat, v, e);
      check("short_err", 32'(e), 32'h1);
      check("short_valid", 32'(v), 32'h0);
      check("short_data", 32'(data_out), 32'hAC3);
      tick(4);

      // long frame: count saturates at 13
      ld_up();
      send_bits(16'h1FFF, 13);
      tick(4);
      check("long_bit_cnt", 32'(bit_cnt), 32'd13);
      ld_down();
      wait_result(10, lat, v, e);
      check("long_err", 32'(e), 32'h1);
      check("long_data", 32'(data_out), 32'hAC3);
      tick(4);

      // timeout: 5 bits, then CLK stalls with LD high
      ld_up();
      send_bits(16'h001F, 5);
      wait_result(100, lat, v, e);
      check("to_err", 32'(e), 32'h1);
      check("to_window", 32'(lat >= 62 && lat <= 66), 32'h1);
      tick(10);
      ld_down();
      wait_result(12, lat, v, e);
      check("to_ldfall_quiet", 32'({v, e}), 32'h0);
      tick(4);
      send_frame(16'h05A5, 12);
      wait_result(10, lat, v, e);
      check("to_recover_valid", 32'(v), 32'h1);
      check("to_recover_data", 32'(data_out), 32'h5A5);
      tick(4);

      // reset mid-frame at bit 6 with LD held high
      ld_up();
      send_bits(16'h0FFF, 6);
      rst = 1'b1;
      tick(3);
      rst = 1'b0;
      check("midrst_data", 32'(data_out), 32'h0);
      send_bits(16'h003F, 6);
      ld_down();
      wait_result(12, lat, v, e);
      check("midrst_quiet", 32'({v, e}), 32'h0);
      tick(4);
      send_frame(16'h03C7, 12);
      wait_result(10, lat, v, e);
      check("midrst_next_valid", 32'(v), 32'h1);
      check("midrst_next_data", 32'(data_out), 32'h3C7);
      tick(4);

`ifdef DAC_RX_FRAME_CNT_EN
      do_reset();
      for (int f = 0; f < 3; f++) begin
         send_frame(16'h0123, 12);
         wait_result(10, lat, v, e);
         tick(4);
      end
      send_frame(16'h0012, 5);
      wait_result(10, lat, v, e);
      tick(4);
      check("frame_cnt", 32'(frame_cnt), 32'd3);
      check("err_cnt", 32'(err_cnt), 32'd1);
`endif

      check("no_overlap", 32'(both_hi), 32'd0);

      // final report
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
